// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the master/slave pair: response codes,
// default bus widths and the master transaction state encoding.
package axi_lite_pkg;

   localparam int AXI_ADDR_WIDTH = 4;
   localparam int AXI_DATA_WIDTH = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      RSP     = 3'd5
   } axi_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI write
// or read transaction and returns the captured response.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W offered, each dropped on its own handshake
// WR_RESP | bready high, waiting for the write response
// RD_REQ  | AR offered until arready
// RD_RESP | rready high, waiting for read data
// RSP     | response held on rsp_* until rsp_ready
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
   parameter int DATA_WIDTH = AXI_DATA_WIDTH
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic [ADDR_WIDTH-1:0]     awaddr,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [DATA_WIDTH-1:0]     wdata,
   output logic [DATA_WIDTH/8-1:0]   wstrb,
   output logic                      wvalid,
   input  logic                      wready,
   input  logic [1:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready,
   output logic [ADDR_WIDTH-1:0]     araddr,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [DATA_WIDTH-1:0]     rdata,
   input  logic [1:0]                rresp,
   input  logic                      rvalid,
   output logic                      rready
);

   axi_state_t                  r_state;
   axi_state_t                  w_next_state;
   logic                        r_aw_done;
   logic                        r_w_done;
   logic [ADDR_WIDTH-1:0]       r_addr;
   logic [DATA_WIDTH-1:0]       r_wdata;
   logic [DATA_WIDTH/8-1:0]     r_wstrb;
   logic                        r_rsp_write;
   logic [DATA_WIDTH-1:0]       r_rsp_rdata;
   logic [1:0]                  r_rsp_resp;

   logic                        w_cmd_acc;
   logic                        w_aw_hs;
   logic                        w_w_hs;
   logic                        w_b_hs;
   logic                        w_r_hs;

   assign w_cmd_acc = cmd_valid && cmd_ready;
   assign w_aw_hs   = awvalid && awready;
   assign w_w_hs    = wvalid && wready;
   assign w_b_hs    = bvalid && bready;
   assign w_r_hs    = rvalid && rready;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // All handshake outputs decode from registered state only, so reset drops them at once.
   always_comb begin
      w_next_state = r_state;
      cmd_ready    = 1'b0;
      awvalid      = 1'b0;
      wvalid       = 1'b0;
      bready       = 1'b0;
      arvalid      = 1'b0;
      rready       = 1'b0;
      rsp_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) w_next_state = cmd_write ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            awvalid = !r_aw_done;
            wvalid  = !r_w_done;
            if ((r_aw_done || awready) && (r_w_done || wready)) w_next_state = WR_RESP;
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) w_next_state = RSP;
         end
         RD_REQ: begin
            arvalid = 1'b1;
            if (arready) w_next_state = RD_RESP;
         end
         RD_RESP: begin
            rready = 1'b1;
            if (rvalid) w_next_state = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= 2'b00;
      end else begin
         if (w_cmd_acc) begin
            r_addr    <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_wstrb   <= cmd_wstrb;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs)  r_w_done  <= 1'b1;
         if (w_b_hs) begin
            r_rsp_write <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= bresp;
         end
         if (w_r_hs) begin
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= rdata;
            r_rsp_resp  <= rresp;
         end
      end
   end

   assign awaddr    = r_addr;
   assign araddr    = r_addr;
   assign wdata     = r_wdata;
   assign wstrb     = r_wstrb;
   assign rsp_write = r_rsp_write;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_resp  = r_rsp_resp;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a small delay-configurable AXI4-Lite
// slave model driven on the falling clock edge.
module tb_axi_lite_master;
   import axi_lite_pkg::*;

   localparam int AW = 4;
   localparam int DW = 32;

   logic          aclk;
   logic          areset;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [3:0]    cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] awaddr;
   logic          awvalid, awready;
   logic [DW-1:0] wdata;
   logic [3:0]    wstrb;
   logic          wvalid, wready;
   logic [1:0]    bresp;
   logic          bvalid, bready;
   logic [AW-1:0] araddr;
   logic          arvalid, arready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rvalid, rready;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   int          cfg_aw_dly, cfg_w_dly, cfg_ar_dly, cfg_r_dly;
   logic [1:0]  cfg_bresp, cfg_rresp;
   logic [31:0] mem [4];

   axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .aclk(aclk), .areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   always @(posedge aclk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   // Slave model: retires the handshakes of the last rising edge, then decides
   // its outputs for the next one. Master outputs depend only on its state.
   initial begin : slave_bfm
      bit            aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, ar_got;
      int            aw_cnt, w_cnt, ar_cnt, r_cnt;
      logic [AW-1:0] aw_a, ar_a;
      logic [31:0]   w_d;
      logic [3:0]    w_s;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_a = 0; ar_a = 0; w_d = 0; w_s = 0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
         end else begin
            if (aw_hs) begin awready = 0; aw_got = 1; aw_cnt = 0; end
            if (w_hs)  begin wready = 0; w_got = 1; w_cnt = 0; end
            if (b_hs)  begin bvalid = 0; aw_got = 0; w_got = 0; end
            if (ar_hs) begin arready = 0; ar_got = 1; ar_cnt = 0; end
            if (r_hs)  begin rvalid = 0; ar_got = 0; r_cnt = 0; end
            if (awvalid && !aw_got && !awready) begin
               if (aw_cnt >= cfg_aw_dly) awready = 1; else aw_cnt++;
            end
            if (wvalid && !w_got && !wready) begin
               if (w_cnt >= cfg_w_dly) wready = 1; else w_cnt++;
            end
            if (aw_got && w_got && !bvalid) begin
               for (int b = 0; b < 4; b++)
                  if (w_s[b]) mem[aw_a[3:2]][8*b +: 8] = w_d[8*b +: 8];
               bvalid = 1;
               bresp  = cfg_bresp;
            end
            if (arvalid && !ar_got && !arready) begin
               if (ar_cnt >= cfg_ar_dly) arready = 1; else ar_cnt++;
            end
            if (ar_got && !rvalid) begin
               if (r_cnt >= cfg_r_dly) begin
                  rvalid = 1;
                  rdata  = mem[ar_a[3:2]];
                  rresp  = cfg_rresp;
               end else r_cnt++;
            end
            aw_hs = awvalid && awready;
            if (aw_hs) aw_a = awaddr;
            w_hs = wvalid && wready;
            if (w_hs) begin w_d = wdata; w_s = wstrb; end
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            if (ar_hs) ar_a = araddr;
            r_hs  = rvalid && rready;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents a command at a falling edge and returns the cycle of acceptance.
   task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int acc);
      int n;
      cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'h1);
      acc = cyc;
      @(negedge aclk);
      cmd_valid = 0;
   endtask

   task automatic wait_rsp(output int rc);
      int n;
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge aclk); n++; end
      chk("rsp_valid_wait", 32'(rsp_valid), 32'h1);
      rc = cyc;
   endtask

   task automatic ack_rsp;
      rsp_ready = 1;
      @(negedge aclk);
      rsp_ready = 0;
   endtask

   initial begin
      int acc, rc, idx, nacc, nrsp, last;
      bit busy, acc_now;
      areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
      cmd_wstrb = 0; rsp_ready = 0;
      cfg_aw_dly = 0; cfg_w_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
      cfg_bresp = RESP_OKAY; cfg_rresp = RESP_OKAY;
      for (int i = 0; i < 4; i++) mem[i] = 0;
      repeat (2) @(negedge aclk);

      chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("rst_awvalid",   32'(awvalid),   32'h0);
      chk("rst_wvalid",    32'(wvalid),    32'h0);
      chk("rst_arvalid",   32'(arvalid),   32'h0);
      chk("rst_bready",    32'(bready),    32'h0);
      chk("rst_rready",    32'(rready),    32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_awaddr",    32'(awaddr),    32'h0);
      chk("rst_wdata",     wdata,          32'h0);
      chk("rst_rsp_rdata", rsp_rdata,      32'h0);
      chk("rst_rsp_resp",  32'(rsp_resp),  32'h0);
      areset = 0;
      @(negedge aclk);

      // zero-wait write then read of the same word
      send(1, 4'h0, 32'hCAFE_BABE, 4'hF, acc);
      wait_rsp(rc);
      chk("wr_latency",   32'(rc - acc),   32'd3);
      chk("wr_rsp_write", 32'(rsp_write), 32'h1);
      chk("wr_rsp_resp",  32'(rsp_resp),  32'h0);
      chk("wr_rsp_rdata", rsp_rdata,      32'h0);
      ack_rsp();
      chk("wr_idle_cmd_ready", 32'(cmd_ready), 32'h1);
      send(0, 4'h0, 32'h0, 4'h0, acc);
      wait_rsp(rc);
      chk("rd_latency",   32'(rc - acc),   32'd3);
      chk("rd_rsp_write", 32'(rsp_write), 32'h0);
      chk("rd_rsp_rdata", rsp_rdata,      32'hCAFE_BABE);
      chk("rd_rsp_resp",  32'(rsp_resp),  32'h0);
      ack_rsp();

      // W channel delayed: AW completes alone, W holds with stable data
      cfg_w_dly = 4;
      send(1, 4'h4, 32'hA5A5_0F0F, 4'hF, acc);
      chk("wd_c1_awvalid", 32'(awvalid), 32'h1);
      chk("wd_c1_wvalid",  32'(wvalid),  32'h1);
      for (int k = 2; k <= 5; k++) begin
         @(negedge aclk);
         chk("wd_awvalid_low", 32'(awvalid), 32'h0);
         chk("wd_wvalid_hold", 32'(wvalid),  32'h1);
         chk("wd_wdata_hold",  wdata,        32'hA5A5_0F0F);
         chk("wd_bready_low",  32'(bready),  32'h0);
      end
      @(negedge aclk);
      chk("wd_wvalid_done", 32'(wvalid), 32'h0);
      chk("wd_bready_high", 32'(bready), 32'h1);
      wait_rsp(rc);
      chk("wd_latency",  32'(rc - acc),  32'd7);
      chk("wd_rsp_resp", 32'(rsp_resp), 32'h0);
      ack_rsp();
      cfg_w_dly = 0;

      // SLVERR write response held while the consumer stalls
      cfg_bresp = RESP_SLVERR;
      send(1, 4'h8, 32'h1234_5678, 4'h3, acc);
      wait_rsp(rc);
      chk("be_latency", 32'(rc - acc), 32'd3);
      for (int k = 0; k < 5; k++) begin
         chk("be_rsp_valid", 32'(rsp_valid), 32'h1);
         chk("be_rsp_resp",  32'(rsp_resp),  32'h2);
         chk("be_rsp_write", 32'(rsp_write), 32'h1);
         chk("be_cmd_ready", 32'(cmd_ready), 32'h0);
         @(negedge aclk);
      end
      ack_rsp();
      chk("be_idle_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("be_idle_rsp_valid", 32'(rsp_valid), 32'h0);
      cfg_bresp = RESP_OKAY;

      // delayed AR and R, EXOKAY passed through
      cfg_ar_dly = 3; cfg_r_dly = 2; cfg_rresp = RESP_EXOKAY;
      send(0, 4'h4, 32'h0, 4'h0, acc);
      for (int k = 1; k <= 4; k++) begin
         chk("rdd_arvalid", 32'(arvalid), 32'h1);
         chk("rdd_araddr",  32'(araddr),  32'h4);
         @(negedge aclk);
      end
      chk("rdd_arvalid_done", 32'(arvalid), 32'h0);
      chk("rdd_rready",       32'(rready),  32'h1);
      wait_rsp(rc);
      chk("rdd_latency", 32'(rc - acc),   32'd8);
      chk("rdd_rdata",   rsp_rdata,      32'hA5A5_0F0F);
      chk("rdd_resp",    32'(rsp_resp),  32'h1);
      chk("rdd_write",   32'(rsp_write), 32'h0);
      ack_rsp();

      // partial-strobe word read back with DECERR
      cfg_ar_dly = 0; cfg_r_dly = 0; cfg_rresp = RESP_DECERR;
      send(0, 4'h8, 32'h0, 4'h0, acc);
      wait_rsp(rc);
      chk("strb_latency", 32'(rc - acc),  32'd3);
      chk("strb_rdata",   rsp_rdata,     32'h0000_5678);
      chk("strb_resp",    32'(rsp_resp), 32'h3);
      ack_rsp();
      cfg_rresp = RESP_OKAY;

      // reset asserted while AW/W are pending
      cfg_aw_dly = 5; cfg_w_dly = 5;
      send(1, 4'hC, 32'hDEAD_BEEF, 4'hF, acc);
      chk("ar_pre_awvalid", 32'(awvalid), 32'h1);
      chk("ar_pre_wvalid",  32'(wvalid),  32'h1);
      #2 areset = 1;
      #1;
      chk("ar_awvalid_async", 32'(awvalid),   32'h0);
      chk("ar_wvalid_async",  32'(wvalid),    32'h0);
      chk("ar_cmd_ready_rst", 32'(cmd_ready), 32'h1);
      @(negedge aclk);
      @(negedge aclk);
      #1 areset = 0;
      cfg_aw_dly = 0; cfg_w_dly = 0;
      @(negedge aclk);
      chk("ar_cmd_ready_post", 32'(cmd_ready), 32'h1);
      send(1, 4'hC, 32'h0BAD_F00D, 4'hF, acc);
      wait_rsp(rc);
      chk("ar_next_latency", 32'(rc - acc),  32'd3);
      chk("ar_next_resp",    32'(rsp_resp), 32'h0);
      ack_rsp();
      chk("ar_next_mem", mem[3], 32'h0BAD_F00D);

      // four back-to-back writes with cmd_valid held high
      idx = 0; nacc = 0; nrsp = 0; last = 0; busy = 0;
      cmd_write = 1; cmd_addr = 4'h0; cmd_wdata = 32'hB0B0_0000; cmd_wstrb = 4'hF;
      cmd_valid = 1; rsp_ready = 1;
      for (int k = 0; k < 60 && nrsp < 4; k++) begin
         acc_now = 0;
         if (busy) chk("b2b_cmd_ready_busy", 32'(cmd_ready), 32'h0);
         if (rsp_valid) begin
            chk("b2b_rsp_write", 32'(rsp_write), 32'h1);
            chk("b2b_rsp_resp",  32'(rsp_resp),  32'h0);
            nrsp++;
            busy = 0;
         end
         if (cmd_valid && cmd_ready) begin
            if (nacc > 0) chk("b2b_spacing", 32'(cyc - last), 32'd4);
            last = cyc;
            nacc++;
            busy = 1;
            acc_now = 1;
         end
         @(negedge aclk);
         if (acc_now) begin
            idx++;
            if (idx == 4) cmd_valid = 0;
            else begin
               cmd_addr  = 4'(idx * 4);
               cmd_wdata = 32'hB0B0_0000 | 32'(idx);
            end
         end
      end
      rsp_ready = 0;
      chk("b2b_accepts",   32'(nacc), 32'd4);
      chk("b2b_responses", 32'(nrsp), 32'd4);
      chk("b2b_idle",      32'(cmd_ready), 32'h1);
      chk("b2b_mem0", mem[0], 32'hB0B0_0000);
      chk("b2b_mem1", mem[1], 32'hB0B0_0001);
      chk("b2b_mem2", mem[2], 32'hB0B0_0002);
      chk("b2b_mem3", mem[3], 32'hB0B0_0003);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
